// File: rtl/mm_tile_sched_if.sv
// Handshake and control bundle between the matrix-multiply sequencer and its
// host, RAM address ports and PPU drain port.
interface mm_tile_sched_if #(
  parameter int AD     = 16,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
);
  localparam int AW = (AD > 1) ? $clog2(AD) : 1;

  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [DIM_W-1:0]  row_tiles;
  logic [DIM_W-1:0]  col_tiles;
  logic [DIM_W-1:0]  k_steps;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              issue;
  logic              psum_clr;
  logic              acc_bank;
  logic [AW-1:0]     acc_addr;
  logic              drain_valid;
  logic              drain_ready;
  logic              drain_bank;
  logic [AW-1:0]     drain_addr;
  logic              drain_pass;
  logic              bias_req;
  logic              tile_done;
  logic              mtrx_done;
  logic              cfg_err;
  logic              busy;

  modport master (
    output start, abort, mode, row_tiles, col_tiles, k_steps, drain_ready,
    input  a_addr, b_addr, issue, psum_clr, acc_bank, acc_addr, drain_valid,
           drain_bank, drain_addr, drain_pass, bias_req, tile_done, mtrx_done,
           cfg_err, busy
  );

  modport slave (
    input  start, abort, mode, row_tiles, col_tiles, k_steps, drain_ready,
    output a_addr, b_addr, issue, psum_clr, acc_bank, acc_addr, drain_valid,
           drain_bank, drain_addr, drain_pass, bias_req, tile_done, mtrx_done,
           cfg_err, busy
  );
endinterface

// File: rtl/mm_tile_sched.sv
// Matrix-multiply tile sequencer: walks b/a/col/row counters to issue MAC ops,
// ping-pongs two accumulator banks and drains each finished tile to the PPU.
module mm_tile_sched #(
  parameter int AD     = 16,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input logic            clk,
  input logic            rst_n,
  mm_tile_sched_if.slave bus
);
  localparam int AW = (AD > 1) ? $clog2(AD) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, MAX = 2'd1, CALC = 2'd2, FLUSH = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [DIM_W-1:0] rows_q, cols_q, k_q;
  logic [DIM_W-1:0] row_q, col_q, a_q;
  logic [AW-1:0]    b_q, drn_addr_q;
  logic             acc_bank_q, pass_q, drn_bank_q;
  logic [1:0]       pend_q, pend_pass_q;
  logic             tile_done_q, bias_q, mtrx_q, cfg_err_q;

  logic cfg_ok, accept, run, issue;
  logic b_last, a_last, col_last, row_last, tile_last, grid_last;
  logic drain_valid, beat, beat_last, flush_done;

  always_comb begin
    cfg_ok      = (bus.mode != 2'd3) && (bus.row_tiles != '0) &&
                  (bus.col_tiles != '0) && (bus.k_steps != '0);
    accept      = (state == IDLE) && bus.start && !bus.abort;
    run         = (state == MAX) || (state == CALC);
    // A new tile may not start on a bank whose previous drain is still open.
    issue       = run && !((b_q == '0) && (a_q == '0) && pend_q[acc_bank_q]);
    b_last      = (b_q == AW'(AD - 1));
    a_last      = (a_q == k_q - DIM_W'(1));
    col_last    = (col_q == cols_q - DIM_W'(1));
    row_last    = (row_q == rows_q - DIM_W'(1));
    tile_last   = b_last && a_last;
    grid_last   = col_last && row_last;
    drain_valid = pend_q[drn_bank_q];
    beat        = drain_valid && bus.drain_ready;
    beat_last   = beat && (drn_addr_q == AW'(AD - 1));
    flush_done  = (state == FLUSH) && beat_last && !pend_q[!drn_bank_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && cfg_ok) state_nxt = (bus.mode == 2'd2) ? CALC : MAX;
        MAX:     if (issue && tile_last && grid_last) state_nxt = CALC;
        CALC:    if (issue && tile_last && grid_last) state_nxt = FLUSH;
        FLUSH:   if (flush_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q <= '0; cols_q <= '0; k_q <= '0;
      row_q <= '0; col_q <= '0; a_q <= '0; b_q <= '0;
      acc_bank_q <= 1'b0; pass_q <= 1'b0; drn_bank_q <= 1'b0; drn_addr_q <= '0;
      pend_q <= '0; pend_pass_q <= '0;
    end else if (bus.abort) begin
      rows_q <= '0; cols_q <= '0; k_q <= '0;
      row_q <= '0; col_q <= '0; a_q <= '0; b_q <= '0;
      acc_bank_q <= 1'b0; pass_q <= 1'b0; drn_bank_q <= 1'b0; drn_addr_q <= '0;
      pend_q <= '0; pend_pass_q <= '0;
    end else begin
      if (accept && cfg_ok) begin
        rows_q <= bus.row_tiles; cols_q <= bus.col_tiles; k_q <= bus.k_steps;
        row_q <= '0; col_q <= '0; a_q <= '0; b_q <= '0;
        acc_bank_q <= 1'b0; drn_bank_q <= 1'b0;
        pass_q <= (bus.mode == 2'd2);
      end else if (issue) begin
        b_q <= b_last ? '0 : b_q + AW'(1);
        if (b_last) a_q <= a_last ? '0 : a_q + DIM_W'(1);
        if (tile_last) begin
          col_q <= col_last ? '0 : col_q + DIM_W'(1);
          if (col_last) row_q <= row_last ? '0 : row_q + DIM_W'(1);
          acc_bank_q <= !acc_bank_q;
          // Grid wrap at the end of MAX leaves counters at zero for CALC.
          if (grid_last) pass_q <= 1'b1;
        end
      end
      if (beat) begin
        drn_addr_q <= beat_last ? '0 : drn_addr_q + AW'(1);
        if (beat_last) drn_bank_q <= !drn_bank_q;
      end
      if (beat_last) pend_q[drn_bank_q] <= 1'b0;
      if (issue && tile_last) begin
        pend_q[acc_bank_q]      <= 1'b1;
        pend_pass_q[acc_bank_q] <= pass_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_done_q <= 1'b0; bias_q <= 1'b0; mtrx_q <= 1'b0; cfg_err_q <= 1'b0;
    end else begin
      tile_done_q <= !bus.abort && (state == CALC) && issue && tile_last;
      bias_q      <= !bus.abort && (state == CALC) && issue && tile_last;
      mtrx_q      <= !bus.abort && flush_done;
      cfg_err_q   <= accept && !cfg_ok;
    end
  end

  always_comb begin
    bus.issue  = issue;
    bus.a_addr = '0;
    bus.b_addr = '0;
    if (issue) begin
      bus.a_addr = ADDR_W'(a_q) + ADDR_W'(row_q) * ADDR_W'(k_q);
      bus.b_addr = ADDR_W'(b_q) + ADDR_W'(a_q) * ADDR_W'(cols_q) * ADDR_W'(AD)
                 + ADDR_W'(col_q) * ADDR_W'(AD);
    end
    bus.psum_clr    = issue && (a_q == '0);
    bus.acc_bank    = acc_bank_q;
    bus.acc_addr    = b_q;
    bus.drain_valid = drain_valid;
    bus.drain_bank  = drn_bank_q;
    bus.drain_addr  = drn_addr_q;
    bus.drain_pass  = pend_pass_q[drn_bank_q];
    bus.bias_req    = bias_q;
    bus.tile_done   = tile_done_q;
    bus.mtrx_done   = mtrx_q;
    bus.cfg_err     = cfg_err_q;
    bus.busy        = (state != IDLE);
  end
endmodule
